letc_core_csr_file: RTL
=======================

# letc_core_csr_file

Machine/supervisor CSR file for the LETC Core: the producer of `csr_implicit_rdata_s` and the consumer of explicit CSR writes retired by writeback. Decode uses its combinational read port for `csr_old_val` and the legality check. Writeback drives explicit writes, trap entry and `mret`. It also owns `mcycle`/`minstret` and the current privilege mode.

## Interface
- `MHARTID`, default 0: value returned by `mhartid`.
- `MTVEC_RESET`, default `32'h00000000`: reset value of `mtvec`.

Ports:
- `i_clk`  in  1  core clock
- `i_rst`  in  1  asynchronous, active-high reset
- `i_rd_idx`  in  12  `csr_idx_t` read index from decode
- `o_rd_val`  out  32  read data, combinational
- `o_rd_illegal`  out  1  index unimplemented, or privilege too low; combinational
- `i_rd_is_write`  in  1  decode intends to write; makes a read-only index illegal
- `i_wen`  in  1  explicit write (`csr_expl_wen` from writeback)
- `i_w_idx`  in  12  write index
- `i_w_val`  in  32  `csr_new_val`
- `i_retire`  in  1  one instruction retired this cycle
- `i_trap`  in  1  trap entry
- `i_trap_cause`  in  32  cause (bit 31 = interrupt)
- `i_trap_pc`  in  32  faulting PC, goes to `mepc`
- `i_trap_tval`  in  32  goes to `mtval`
- `i_mret`  in  1  `mret` retired
- `i_mtip`, `i_msip`, `i_meip`  in  1 each  interrupt lines
- `o_implicit`  out  struct  `csr_implicit_rdata_s`, registered state

## Operation
Implemented CSRs:
- M-mode: `mstatus`, `misa` (RO, RV32IMA+S+U), `mie`, `mip`, `mtvec`, `mscratch`, `mepc`, `mcause`, `mtval`, `mideleg`, `medeleg`, `mhartid` (RO), `mcycle[h]`, `minstret[h]`.
- S-mode: `sscratch`, `sepc`, `scause`, `stvec`, `satp`.
- U-mode: `cycle[h]`, `instret[h]` (RO aliases).
- Any other index: read 0 with `o_rd_illegal`=1.

`o_rd_illegal` is set when any of the following holds:
- index is unimplemented;
- `idx[9:8]` > `current_priv`;
- `i_rd_is_write` and `idx[11:10]==2'b11`.

The write port is trusted; decode has already checked legality.

WARL rules:
- `mstatus` writable bits: SIE, MIE, SPIE, MPIE, SPP, MPP, MPRV, SUM, MXR. All others read 0.
- `mstatus.MPP` write of `2'b10` keeps the old value.
- `mtvec` MODE write of 2 or 3 keeps the old MODE.
- `mepc`/`sepc` bits [1:0] read 0.
- `mip`: MTIP/MSIP/MEIP are read-only, registered copies of the inputs (one-cycle delay). SSIP/STIP/SEIP are writable.

Trap entry (`i_trap`):
- `mepc`←pc, `mcause`←cause, `mtval`←tval.
- MPIE←MIE, MIE←0, MPP←`current_priv`, `current_priv`←M.

`mret`:
- MIE←MPIE, MPIE←1.
- `current_priv`←MPP, MPP←U.
- MPRV←0 if MPP≠M.

Counters:
- `mcycle` increments every cycle; `minstret` increments on `i_retire`.
- Both are 64-bit and wrap from all-ones to 0.
- A write to the low or high half replaces that half only. The other half does not increment that cycle, so no carry crosses into a just-written half.

Simultaneous events (per register):
- `i_trap` wins over `i_mret`, and `i_mret` wins over `i_wen`. The losing update to the same register is dropped.
- `i_wen` to a counter wins over that counter's increment.
- `i_trap` and `i_mret` together is a protocol violation; the block applies the trap.

Reset values:
- All CSRs 0 except `mtvec`=`MTVEC_RESET`.
- `current_priv`=M.
- Counters 0.
- `o_rd_val`/`o_rd_illegal` follow the reset state combinationally.

## Timing
- Writes, trap and `mret` commit on the rising edge and are visible on both read ports the next cycle. There is no write-to-read bypass; the pipeline handles the hazard.
- `o_implicit` is purely register outputs: zero combinational path from any input.
- Read port: zero-cycle combinational mux on `i_rd_idx`.
- Reset asserted mid-operation clears state immediately (async); the first increment happens on the first edge after deassertion.

## Structure
Additions to `letc_core_pkg`:
- `CSR_IDX_*` constants for every implemented index;
- `MSTATUS_*_BIT` field positions;
- `MSTATUS_WMASK`;
- `MISA_VAL`.

Sub-module `letc_core_csr_counter64`:
- 64-bit counter with an increment enable;
- separate low/high write enables plus write data;
- used twice, for `mcycle` and `minstret`.

## Test plan
- **Reset:** after reset, `current_priv`=M, `mtvec`=`MTVEC_RESET`, `mcycle` reads 0 then 1 one cycle later.
- **mstatus WARL:** write `mstatus`=`32'hFFFF_FFFF`, read back `32'h000E_19AA`. Then write MPP=`2'b10`; MPP stays `2'b11`.
- **Trap entry:** MIE=1, priv U, pulse `i_trap` with cause 8, pc `32'h1000`. Expect `mepc`=`32'h1000`, `mcause`=8, MIE=0, MPIE=1, MPP=U, priv=M. Then `mret` restores priv U, MIE=1.
- **Counter carry and write priority:** write `minstret`=`32'hFFFF_FFFF` with `i_retire` held. Next cycle `minstreth`=0; the following retire gives `minstret`=0, `minstreth`=1. `i_wen` to `mcycle` plus the implicit increment: the written value wins.
- **Illegal accesses:** in U-mode, read `mstatus` gives `o_rd_illegal`=1. Read `cycle` gives 0. With `i_rd_is_write`, `cycle` gives 1. Index `32'h7C0` gives 1.
- **Interrupt lines:** `i_mtip` 0→1 gives `mip[7]`=1 exactly one cycle later. A write of 0 to `mip[7]` has no effect.

Source files
------------

// File: rtl/letc_core_pkg.sv
// Shared LETC core types and constants: CSR indices, mstatus layout, privilege
// modes and the implicit CSR state bundle handed to the rest of the pipeline.
package letc_core_pkg;

    typedef logic [11:0] csr_idx_t;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_e;

    // Machine-mode CSR indices
    localparam csr_idx_t CSR_IDX_MSTATUS   = 12'h300;
    localparam csr_idx_t CSR_IDX_MISA      = 12'h301;
    localparam csr_idx_t CSR_IDX_MEDELEG   = 12'h302;
    localparam csr_idx_t CSR_IDX_MIDELEG   = 12'h303;
    localparam csr_idx_t CSR_IDX_MIE       = 12'h304;
    localparam csr_idx_t CSR_IDX_MTVEC     = 12'h305;
    localparam csr_idx_t CSR_IDX_MSCRATCH  = 12'h340;
    localparam csr_idx_t CSR_IDX_MEPC      = 12'h341;
    localparam csr_idx_t CSR_IDX_MCAUSE    = 12'h342;
    localparam csr_idx_t CSR_IDX_MTVAL     = 12'h343;
    localparam csr_idx_t CSR_IDX_MIP       = 12'h344;
    localparam csr_idx_t CSR_IDX_MCYCLE    = 12'hB00;
    localparam csr_idx_t CSR_IDX_MINSTRET  = 12'hB02;
    localparam csr_idx_t CSR_IDX_MCYCLEH   = 12'hB80;
    localparam csr_idx_t CSR_IDX_MINSTRETH = 12'hB82;
    localparam csr_idx_t CSR_IDX_MHARTID   = 12'hF14;

    // Supervisor-mode CSR indices
    localparam csr_idx_t CSR_IDX_SSCRATCH  = 12'h140;
    localparam csr_idx_t CSR_IDX_SEPC      = 12'h141;
    localparam csr_idx_t CSR_IDX_SCAUSE    = 12'h142;
    localparam csr_idx_t CSR_IDX_STVEC     = 12'h105;
    localparam csr_idx_t CSR_IDX_SATP      = 12'h180;

    // User-mode read-only counter aliases
    localparam csr_idx_t CSR_IDX_CYCLE     = 12'hC00;
    localparam csr_idx_t CSR_IDX_INSTRET   = 12'hC02;
    localparam csr_idx_t CSR_IDX_CYCLEH    = 12'hC80;
    localparam csr_idx_t CSR_IDX_INSTRETH  = 12'hC82;

    // mstatus field positions (MPP is two bits starting here)
    localparam int MSTATUS_SIE_BIT  = 1;
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_SPIE_BIT = 5;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_SPP_BIT  = 8;
    localparam int MSTATUS_MPP_BIT  = 11;
    localparam int MSTATUS_MPRV_BIT = 17;
    localparam int MSTATUS_SUM_BIT  = 18;
    localparam int MSTATUS_MXR_BIT  = 19;

    localparam logic [31:0] MSTATUS_WMASK = 32'h000E_19AA;

    // MXL=32-bit; extensions A, I, M, S, U
    localparam logic [31:0] MISA_VAL = 32'h4014_1101;

    // Software-writable mip bits (SSIP, STIP, SEIP) and the mie enable bits
    localparam logic [31:0] MIP_SW_MASK = 32'h0000_0222;
    localparam logic [31:0] MIE_WMASK   = 32'h0000_0AAA;

    // Registered CSR state consumed by fetch/decode/memory without a read port
    typedef struct packed {
        priv_e       priv;
        logic [31:0] mstatus;
        logic [31:0] mie;
        logic [31:0] mip;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] mideleg;
        logic [31:0] medeleg;
        logic [31:0] stvec;
        logic [31:0] sepc;
        logic [31:0] satp;
    } csr_implicit_rdata_s;

    // Only listed fields stick; a reserved MPP encoding keeps the old mode
    function automatic logic [31:0] mstatus_warl(input logic [31:0] old_val,
                                                 input logic [31:0] new_val);
        logic [31:0] r;
        r = new_val & MSTATUS_WMASK;
        if (r[MSTATUS_MPP_BIT +: 2] == 2'b10) begin
            r[MSTATUS_MPP_BIT +: 2] = old_val[MSTATUS_MPP_BIT +: 2];
        end
        return r;
    endfunction

    // Only direct/vectored modes are legal; anything else keeps the old mode
    function automatic logic [31:0] mtvec_warl(input logic [31:0] old_val,
                                               input logic [31:0] new_val);
        logic [31:0] r;
        r = new_val;
        if (new_val[1]) begin
            r[1:0] = old_val[1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/letc_core_csr_counter64.sv
// 64-bit free-running counter with per-half write ports; a write to either
// half suppresses the increment so no carry lands in freshly written data.
module letc_core_csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wen_lo,
    input  logic        wen_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    // Written halves take priority over the increment, which wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (wen_lo || wen_hi) begin
            // NOTE: non-blocking assignments keep every register update in this
            // edge based on pre-edge values, so the two halves never race.
            if (wen_lo) count[31:0]  <= wdata;
            if (wen_hi) count[63:32] <= wdata;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/letc_core_csr_file.sv
// Machine/supervisor CSR file: combinational read port for decode, explicit
// writes plus trap/mret from writeback, counters and current privilege mode.
module letc_core_csr_file
    import letc_core_pkg::*;
#(
    parameter logic [31:0] MHARTID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  csr_idx_t            i_rd_idx,
    output logic [31:0]         o_rd_val,
    output logic                o_rd_illegal,
    input  logic                i_rd_is_write,
    input  logic                i_wen,
    input  csr_idx_t            i_w_idx,
    input  logic [31:0]         i_w_val,
    input  logic                i_retire,
    input  logic                i_trap,
    input  logic [31:0]         i_trap_cause,
    input  logic [31:0]         i_trap_pc,
    input  logic [31:0]         i_trap_tval,
    input  logic                i_mret,
    input  logic                i_mtip,
    input  logic                i_msip,
    input  logic                i_meip,
    output csr_implicit_rdata_s o_implicit
);

    priv_e       priv;
    logic [31:0] mstatus, mie, mtvec, mscratch, mepc, mcause, mtval;
    logic [31:0] mideleg, medeleg, mip_sw;
    logic [31:0] sscratch, sepc, scause, stvec, satp;
    logic        mtip_q, msip_q, meip_q;
    logic [31:0] mip;
    logic [63:0] mcycle, minstret;
    logic        rd_implemented;

    assign mip = mip_sw | {20'd0, meip_q, 3'd0, mtip_q, 3'd0, msip_q, 3'd0};

    letc_core_csr_counter64 u_mcycle (
        .clk    (i_clk),
        .rst    (i_rst),
        .inc    (1'b1),
        .wen_lo (i_wen && (i_w_idx == CSR_IDX_MCYCLE)),
        .wen_hi (i_wen && (i_w_idx == CSR_IDX_MCYCLEH)),
        .wdata  (i_w_val),
        .count  (mcycle)
    );

    letc_core_csr_counter64 u_minstret (
        .clk    (i_clk),
        .rst    (i_rst),
        .inc    (i_retire),
        .wen_lo (i_wen && (i_w_idx == CSR_IDX_MINSTRET)),
        .wen_hi (i_wen && (i_w_idx == CSR_IDX_MINSTRETH)),
        .wdata  (i_w_val),
        .count  (minstret)
    );

    // Trap-affected state: trap beats mret, mret beats an explicit write
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            priv    <= PRIV_M;
            mstatus <= '0;
            mepc    <= '0;
            mcause  <= '0;
            mtval   <= '0;
        end else if (i_trap) begin
            priv                           <= PRIV_M;
            mstatus[MSTATUS_MPIE_BIT]      <= mstatus[MSTATUS_MIE_BIT];
            mstatus[MSTATUS_MIE_BIT]       <= 1'b0;
            mstatus[MSTATUS_MPP_BIT +: 2]  <= priv;
            mepc                           <= {i_trap_pc[31:2], 2'b00};
            mcause                         <= i_trap_cause;
            mtval                          <= i_trap_tval;
        end else if (i_mret) begin
            priv                           <= priv_e'(mstatus[MSTATUS_MPP_BIT +: 2]);
            mstatus[MSTATUS_MIE_BIT]       <= mstatus[MSTATUS_MPIE_BIT];
            mstatus[MSTATUS_MPIE_BIT]      <= 1'b1;
            mstatus[MSTATUS_MPP_BIT +: 2]  <= PRIV_U;
            if (mstatus[MSTATUS_MPP_BIT +: 2] != PRIV_M) begin
                mstatus[MSTATUS_MPRV_BIT] <= 1'b0;
            end
        end else if (i_wen) begin
            case (i_w_idx)
                CSR_IDX_MSTATUS: mstatus <= mstatus_warl(mstatus, i_w_val);
                CSR_IDX_MEPC:    mepc    <= {i_w_val[31:2], 2'b00};
                CSR_IDX_MCAUSE:  mcause  <= i_w_val;
                CSR_IDX_MTVAL:   mtval   <= i_w_val;
                default: ;
            endcase
        end
    end

    // CSRs touched only by explicit writes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mie      <= '0;
            mtvec    <= MTVEC_RESET;
            mscratch <= '0;
            mideleg  <= '0;
            medeleg  <= '0;
            mip_sw   <= '0;
            sscratch <= '0;
            sepc     <= '0;
            scause   <= '0;
            stvec    <= '0;
            satp     <= '0;
        end else if (i_wen) begin
            case (i_w_idx)
                CSR_IDX_MIE:      mie      <= i_w_val & MIE_WMASK;
                CSR_IDX_MTVEC:    mtvec    <= mtvec_warl(mtvec, i_w_val);
                CSR_IDX_MSCRATCH: mscratch <= i_w_val;
                CSR_IDX_MIDELEG:  mideleg  <= i_w_val;
                CSR_IDX_MEDELEG:  medeleg  <= i_w_val;
                CSR_IDX_MIP:      mip_sw   <= i_w_val & MIP_SW_MASK;
                CSR_IDX_SSCRATCH: sscratch <= i_w_val;
                CSR_IDX_SEPC:     sepc     <= {i_w_val[31:2], 2'b00};
                CSR_IDX_SCAUSE:   scause   <= i_w_val;
                CSR_IDX_STVEC:    stvec    <= i_w_val;
                CSR_IDX_SATP:     satp     <= i_w_val;
                default: ;
            endcase
        end
    end

    // Sample the machine interrupt lines; mip shows them one cycle later
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mtip_q <= 1'b0;
            msip_q <= 1'b0;
            meip_q <= 1'b0;
        end else begin
            mtip_q <= i_mtip;
            msip_q <= i_msip;
            meip_q <= i_meip;
        end
    end

    // Combinational read mux and legality check for decode
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch
        // is inferred for indices the case does not list.
        o_rd_val       = '0;
        rd_implemented = 1'b1;
        case (i_rd_idx)
            CSR_IDX_MSTATUS:   o_rd_val = mstatus;
            CSR_IDX_MISA:      o_rd_val = MISA_VAL;
            CSR_IDX_MEDELEG:   o_rd_val = medeleg;
            CSR_IDX_MIDELEG:   o_rd_val = mideleg;
            CSR_IDX_MIE:       o_rd_val = mie;
            CSR_IDX_MTVEC:     o_rd_val = mtvec;
            CSR_IDX_MSCRATCH:  o_rd_val = mscratch;
            CSR_IDX_MEPC:      o_rd_val = mepc;
            CSR_IDX_MCAUSE:    o_rd_val = mcause;
            CSR_IDX_MTVAL:     o_rd_val = mtval;
            CSR_IDX_MIP:       o_rd_val = mip;
            CSR_IDX_MHARTID:   o_rd_val = MHARTID;
            CSR_IDX_SSCRATCH:  o_rd_val = sscratch;
            CSR_IDX_SEPC:      o_rd_val = sepc;
            CSR_IDX_SCAUSE:    o_rd_val = scause;
            CSR_IDX_STVEC:     o_rd_val = stvec;
            CSR_IDX_SATP:      o_rd_val = satp;
            CSR_IDX_MCYCLE,
            CSR_IDX_CYCLE:     o_rd_val = mcycle[31:0];
            CSR_IDX_MCYCLEH,
            CSR_IDX_CYCLEH:    o_rd_val = mcycle[63:32];
            CSR_IDX_MINSTRET,
            CSR_IDX_INSTRET:   o_rd_val = minstret[31:0];
            CSR_IDX_MINSTRETH,
            CSR_IDX_INSTRETH:  o_rd_val = minstret[63:32];
            default:           rd_implemented = 1'b0;
        endcase
        o_rd_illegal = !rd_implemented
                    || (i_rd_idx[9:8] > priv)
                    || (i_rd_is_write && (i_rd_idx[11:10] == 2'b11));
    end

    assign o_implicit = '{
        priv:    priv,
        mstatus: mstatus,
        mie:     mie,
        mip:     mip,
        mtvec:   mtvec,
        mepc:    mepc,
        mideleg: mideleg,
        medeleg: medeleg,
        stvec:   stvec,
        sepc:    sepc,
        satp:    satp
    };

endmodule
